decoding_graph_controller: RTL

Sequencer for the decoding graph in the next generation of the decoder. It streams syndrome rounds in through a valid/ready port and assembles them into the graph's measurement vector. It then drives the stage FSM (load, merge-settle, grow loop) using pipelined busy/odd reductions, and streams every PU root out through a valid/ready port. The measurement round count is now independent of the code distances.

---
 rtl/decoding_graph_controller_pkg.sv | 37 +++
 rtl/decoding_graph_controller_or_reduce.sv | 20 ++
 rtl/decoding_graph_controller.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/decoding_graph_controller_pkg.sv
// rtl/decoding_graph_controller_pkg.sv - shared stage encodings and controller states for the decoding graph
// Build option DECODING_GRAPH_CTRL_ITER_LIMIT_EN is consumed by decoding_graph_controller.
package decoding_graph_controller_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd4;

  typedef logic [2:0] ctrl_state_t;

  localparam ctrl_state_t S_IDLE   = 3'd0;
  localparam ctrl_state_t S_LOAD   = 3'd1;
  localparam ctrl_state_t S_MERGE  = 3'd2;
  localparam ctrl_state_t S_GROW   = 3'd3;
  localparam ctrl_state_t S_REPORT = 3'd4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [STAGE_WIDTH-1:0] stage_of(input ctrl_state_t s);
    case (s)
      S_LOAD:   return STAGE_MEASUREMENT_LOADING;
      S_MERGE:  return STAGE_MERGE;
      S_GROW:   return STAGE_GROW;
      S_REPORT: return STAGE_RESULT_VALID;
      default:  return STAGE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/decoding_graph_controller_or_reduce.sv
// rtl/decoding_graph_controller_or_reduce.sv - registered OR reduction of a per-PU flag vector
module pipelined_or_reduce #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_any
);

  logic r_any;

  always_ff @(posedge clk) begin
    if (!reset) r_any <= 1'b0;
    else        r_any <= |i_data;
  end

  assign o_any = r_any;

endmodule

// File: rtl/decoding_graph_controller.sv
// rtl/decoding_graph_controller.sv - syndrome loader, merge/grow sequencer and root streamer
// Optional growth cap: define DECODING_GRAPH_CTRL_ITER_LIMIT_EN.
module decoding_graph_controller
  import decoding_graph_controller_pkg::*;
#(
  parameter int CODE_DISTANCE_X    = 3,
  parameter int CODE_DISTANCE_Z    = 2,
  parameter int MEASUREMENT_ROUNDS = 3,
  parameter int ADDRESS_WIDTH      = 3 * $clog2(max3(CODE_DISTANCE_X, CODE_DISTANCE_Z, MEASUREMENT_ROUNDS)),
  parameter int MAX_ITERATIONS     = 16,
  parameter int SETTLE_CYCLES      = 2,
  localparam int LAYER      = CODE_DISTANCE_X * CODE_DISTANCE_Z,
  localparam int PU_COUNT   = LAYER * MEASUREMENT_ROUNDS,
  localparam int IDX_WIDTH  = (PU_COUNT > 1) ? $clog2(PU_COUNT) : 1,
  localparam int ITER_WIDTH = $clog2(MAX_ITERATIONS + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [LAYER-1:0]                  meas_in,
  input  logic                              meas_valid,
  output logic                              meas_ready,
  output logic [PU_COUNT-1:0]               measurements,
  output logic [STAGE_WIDTH-1:0]            stage,
  output logic                              global_stage,
  input  logic [PU_COUNT-1:0]               graph_busy,
  input  logic [PU_COUNT-1:0]               graph_odd,
  input  logic [ADDRESS_WIDTH*PU_COUNT-1:0] graph_roots,
  output logic [ADDRESS_WIDTH-1:0]          root_data,
  output logic [IDX_WIDTH-1:0]              root_index,
  output logic                              root_valid,
  output logic                              root_last,
  input  logic                              root_ready,
  output logic [ITER_WIDTH-1:0]             iter_count,
  output logic                              timeout,
  output logic                              done
);

  localparam int RW = $clog2(MEASUREMENT_ROUNDS + 1);
  localparam int DW = $clog2(SETTLE_CYCLES + 1);

  ctrl_state_t                r_state, w_next_state;
  logic [STAGE_WIDTH-1:0]     r_stage;
  logic                       r_global_stage, r_done;
  logic [PU_COUNT-1:0]        r_meas;
  logic [RW-1:0]              r_round, w_wr_layer;
  logic [DW-1:0]              r_dwell;
  logic [ITER_WIDTH-1:0]      r_iter;
  logic [ADDRESS_WIDTH-1:0]   r_root_data, w_root_sel;
  logic [IDX_WIDTH-1:0]       r_root_index, w_root_pick;
  logic                       r_root_valid, r_root_last;
  logic                       w_busy_any, w_odd_any, w_accept, w_settled, w_cap, w_beat;

  pipelined_or_reduce #(.WIDTH(PU_COUNT)) u_busy_or (
    .clk(clk), .reset(reset), .i_data(graph_busy), .o_any(w_busy_any)
  );

  pipelined_or_reduce #(.WIDTH(PU_COUNT)) u_odd_or (
    .clk(clk), .reset(reset), .i_data(graph_odd), .o_any(w_odd_any)
  );

  assign meas_ready = reset && (r_state == S_IDLE || r_state == S_LOAD);
  assign w_accept   = meas_valid && meas_ready;
  assign w_wr_layer = (r_state == S_IDLE) ? '0 : r_round;
  assign w_settled  = r_dwell >= DW'(SETTLE_CYCLES - 1);
  assign w_beat     = r_root_valid && root_ready;

`ifdef DECODING_GRAPH_CTRL_ITER_LIMIT_EN
  logic r_timeout;
  assign w_cap   = r_iter == ITER_WIDTH'(MAX_ITERATIONS);
  assign timeout = r_timeout;
`else
  assign w_cap   = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next_state = (MEASUREMENT_ROUNDS == 1) ? S_MERGE : S_LOAD;
      S_LOAD:   if (w_accept && r_round == RW'(MEASUREMENT_ROUNDS - 1)) w_next_state = S_MERGE;
      S_MERGE:  if (w_settled && !w_busy_any)
                  w_next_state = (w_odd_any && !w_cap) ? S_GROW : S_REPORT;
      S_GROW:   w_next_state = S_MERGE;
      S_REPORT: if (w_beat && r_root_last) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Entering REPORT loads beat 0; each handshake preloads the following beat.
  always_comb begin
    w_root_pick = (r_state == S_MERGE) ? '0 : r_root_index + IDX_WIDTH'(1);
    w_root_sel  = '0;
    for (int p = 0; p < PU_COUNT; p++)
      if (w_root_pick == IDX_WIDTH'(p)) w_root_sel = graph_roots[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_stage        <= STAGE_IDLE;
      r_global_stage <= 1'b0;
      r_done         <= 1'b0;
      r_meas         <= '0;
      r_round        <= '0;
      r_dwell        <= '0;
      r_iter         <= '0;
      r_root_data    <= '0;
      r_root_index   <= '0;
      r_root_valid   <= 1'b0;
      r_root_last    <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_stage        <= stage_of(w_next_state);
      r_global_stage <= w_next_state != r_state;
      r_done         <= (r_state == S_REPORT) && (w_next_state == S_IDLE);

      if (w_accept) begin
        for (int k = 0; k < MEASUREMENT_ROUNDS; k++)
          if (w_wr_layer == RW'(k)) r_meas[k*LAYER +: LAYER] <= meas_in;
        r_round <= w_wr_layer + RW'(1);
        if (r_state == S_IDLE) r_iter <= '0;
      end

      if (r_state != S_MERGE) r_dwell <= '0;
      else if (!w_settled)    r_dwell <= r_dwell + DW'(1);

      if (r_state == S_MERGE && w_next_state == S_GROW && r_iter != '1)
        r_iter <= r_iter + ITER_WIDTH'(1);

      if (r_state == S_MERGE && w_next_state == S_REPORT) begin
        r_root_valid <= 1'b1;
        r_root_index <= '0;
        r_root_data  <= w_root_sel;
        r_root_last  <= PU_COUNT == 1;
      end else if (r_state == S_REPORT && w_beat) begin
        if (r_root_last) begin
          r_root_valid <= 1'b0;
          r_root_last  <= 1'b0;
        end else begin
          r_root_index <= w_root_pick;
          r_root_data  <= w_root_sel;
          r_root_last  <= w_root_pick == IDX_WIDTH'(PU_COUNT - 1);
        end
      end
    end
  end

`ifdef DECODING_GRAPH_CTRL_ITER_LIMIT_EN
  always_ff @(posedge clk) begin
    if (!reset)                                    r_timeout <= 1'b0;
    else if (w_accept && r_state == S_IDLE)        r_timeout <= 1'b0;
    else if (r_state == S_MERGE && w_settled && !w_busy_any && w_odd_any && w_cap)
                                                   r_timeout <= 1'b1;
  end
`endif

  assign measurements = r_meas;
  assign stage        = r_stage;
  assign global_stage = r_global_stage;
  assign root_data    = r_root_data;
  assign root_index   = r_root_index;
  assign root_valid   = r_root_valid;
  assign root_last    = r_root_last;
  assign iter_count   = r_iter;
  assign done         = r_done;

endmodule
